// File: rtl/tube_pkg.sv
// Shared constants and width helpers for the Tube register-channel FIFOs.
package tube_pkg;

  localparam logic [7:0] TUBE_EMPTY_DATA = 8'hAA;

  function automatic int tube_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int tube_cnt_w(input int depth);
    return tube_ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/tube_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset (maps to distributed RAM).
module tube_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tube_sync_fifo.sv
// Single-clock Tube data-register FIFO with flush, sticky error flags and threshold/irq outputs.
// Two-byte (R3-style) thresholds are built only when TUBE_FIFO_MODE2_EN is defined.
module tube_sync_fifo
  import tube_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 16,
  parameter logic [WIDTH-1:0] EMPTY_DATA = WIDTH'(TUBE_EMPTY_DATA)
) (
  input  logic                          phi2,
  input  logic                          rst_b,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  input  logic                          mode2,
  input  logic                          irq_en,
  output logic [tube_cnt_w(DEPTH)-1:0]  count,
  output logic                          data_available,
  output logic                          not_full,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          irq
);

  localparam int PW = tube_ptr_w(DEPTH);
  localparam int CW = tube_cnt_w(DEPTH);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q, underflow_q;
  logic             is_empty, is_full;
  logic             wr_ok, rd_ok, wr_rej, rd_rej;
  logic [WIDTH-1:0] ram_rdata;

  // Strobes are level-sampled, one access per phi2 edge while high. Acceptance is
  // judged on the pre-edge count; flush overrides both strobes.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign wr_ok    = wr_en & ~flush & ~is_full;
  assign rd_ok    = rd_en & ~flush & ~is_empty;
  assign wr_rej   = wr_en & ~flush & is_full;
  assign rd_rej   = rd_en & ~flush & is_empty;

  always_ff @(posedge phi2 or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overflow_q  <= overflow_q  | wr_rej;
      underflow_q <= underflow_q | rd_rej;
    end
  end

  tube_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (phi2),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign rd_data   = is_empty ? EMPTY_DATA : ram_rdata;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef TUBE_FIFO_MODE2_EN
  // Two-byte mode: a reader wants a pair, a writer needs room for a pair.
  assign data_available = mode2 ? (count_q >= CW'(2))         : ~is_empty;
  assign not_full       = mode2 ? (count_q <= CW'(DEPTH - 2)) : ~is_full;
`else
  logic unused_mode2;
  assign unused_mode2   = mode2;
  assign data_available = ~is_empty;
  assign not_full       = ~is_full;
`endif

  assign irq = irq_en & data_available;

endmodule

// File: tb/tb_tube_sync_fifo.sv
// Directed bench for tube_sync_fifo: queue-based reference model plus a negedge monitor.
module tb_tube_sync_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
`ifdef TUBE_FIFO_MODE2_EN
  localparam bit M2 = 1'b1;
`else
  localparam bit M2 = 1'b0;
`endif

  logic             phi2 = 1'b0;
  logic             rst_b;
  logic             flush, wr_en, rd_en, mode2, irq_en;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic [4:0]       count;
  logic             data_available, not_full, overflow, underflow, irq;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             m_ov = 1'b0, m_un = 1'b0;

  tube_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .phi2           (phi2),
    .rst_b          (rst_b),
    .flush          (flush),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .mode2          (mode2),
    .irq_en         (irq_en),
    .count          (count),
    .data_available (data_available),
    .not_full       (not_full),
    .overflow       (overflow),
    .underflow      (underflow),
    .irq            (irq)
  );

  // clock / reset
  always #5 phi2 = ~phi2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pushes accepted writes, pops accepted reads on each edge
  always @(posedge phi2 or negedge rst_b) begin
    if (!rst_b) begin
      exp_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      int cnt;
      cnt = exp_q.size();
      if (rd_en && cnt > 0) void'(exp_q.pop_front());
      if (rd_en && cnt == 0) m_un = 1'b1;
      if (wr_en && cnt < DEPTH) exp_q.push_back(wr_data);
      if (wr_en && cnt >= DEPTH) m_ov = 1'b1;
    end
  end

  // monitor: compares every presented output against the model
  always @(negedge phi2) begin
    int  cnt;
    bit  two;
    logic exp_da;
    cnt = exp_q.size();
    two = M2 && (mode2 === 1'b1);
    exp_da = two ? (cnt >= 2) : (cnt >= 1);
    check("mon_rd_data", rd_data, (cnt > 0) ? exp_q[0] : 8'hAA);
    check("mon_count", count, cnt);
    check("mon_data_available", data_available, exp_da);
    check("mon_not_full", not_full, two ? (cnt <= DEPTH - 2) : (cnt <= DEPTH - 1));
    check("mon_overflow", overflow, m_ov);
    check("mon_underflow", underflow, m_un);
    check("mon_irq", irq, irq_en & exp_da);
  end

  // driver tasks: inputs change 2 time units after the active edge
  task automatic access(input bit wr, input logic [WIDTH-1:0] d, input bit rd);
    wr_en = wr; wr_data = d; rd_en = rd;
    @(posedge phi2); #2;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_flush(input bit wr, input bit rd);
    flush = 1'b1; wr_en = wr; wr_data = 8'h99; rd_en = rd;
    @(posedge phi2); #2;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_data = '0; mode2 = 1'b0; irq_en = 1'b0;
    repeat (2) @(posedge phi2);
    #2 rst_b = 1'b1;

    // reset state
    check("rst_count", count, 0);
    check("rst_rd_data", rd_data, 8'hAA);
    check("rst_da", data_available, 0);
    check("rst_nf", not_full, 1);
    check("rst_ov_un_irq", {overflow, underflow, irq}, 0);

    // basic ordering
    access(1, 8'h11, 0); access(1, 8'h22, 0); access(1, 8'h33, 0);
    check("t1_count", count, 3);
    check("t1_head", rd_data, 8'h11);
    access(0, 0, 1); check("t1_rd1", rd_data, 8'h22);
    access(0, 0, 1); check("t1_rd2", rd_data, 8'h33);
    access(0, 0, 1);
    check("t1_empty_data", rd_data, 8'hAA);
    check("t1_empty_da", data_available, 0);

    // overflow on 17th write, flush ignores simultaneous strobes
    for (int i = 0; i < 17; i++) access(1, 8'(i + 1), 0);
    check("t2_count", count, 16);
    check("t2_nf", not_full, 0);
    check("t2_ov", overflow, 1);
    check("t2_head", rd_data, 8'h01);
    do_flush(1, 1);
    check("t2_fl_count", count, 0);
    check("t2_fl_ov", overflow, 0);
    check("t2_fl_data", rd_data, 8'hAA);

    // underflow, then simultaneous write+read on empty
    access(0, 0, 1);
    check("t3_un", underflow, 1);
    check("t3_count", count, 0);
    do_flush(0, 0);
    access(1, 8'h5A, 1);
    check("t3_sim_count", count, 1);
    check("t3_sim_data", rd_data, 8'h5A);
    check("t3_sim_un", underflow, 1);
    do_flush(0, 0);

    // two-byte mode thresholds and irq
    mode2 = 1'b1; irq_en = 1'b1;
    access(1, 8'h30, 0);
    check("t4_da1", data_available, M2 ? 0 : 1);
    check("t4_irq1", irq, M2 ? 0 : 1);
    access(1, 8'h31, 0);
    check("t4_da2", data_available, 1);
    check("t4_irq2", irq, 1);
    for (int i = 2; i < 15; i++) access(1, 8'(8'h30 + i), 0);
    check("t4_c15", count, 15);
    check("t4_nf15", not_full, M2 ? 0 : 1);
    access(1, 8'h3F, 0);
    mode2 = 1'b0; irq_en = 1'b0;

    // full: simultaneous write+read
    access(1, 8'hEE, 1);
    check("t5_count", count, 15);
    check("t5_head", rd_data, 8'h31);
    check("t5_ov", overflow, 1);
    do_flush(0, 0);

    // 40 bytes through the pointer wrap
    for (int i = 0; i < 10; i++) access(1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 30; i++) access(1, 8'(8'h80 + i), 1);
    check("t6_mid_count", count, 10);
    check("t6_mid_head", rd_data, 8'h94);
    for (int i = 0; i < 10; i++) access(0, 0, 1);
    check("t6_end_count", count, 0);
    check("t6_end_un", underflow, 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) access(1, 8'(8'h60 + i), 0);
    check("t7_pre_count", count, 5);
    #1 rst_b = 1'b0;
    #1;
    check("t7_rst_count", count, 0);
    check("t7_rst_data", rd_data, 8'hAA);
    check("t7_rst_da", data_available, 0);
    check("t7_rst_nf", not_full, 1);
    check("t7_rst_irq", irq, 0);
    @(posedge phi2); #2 rst_b = 1'b1;
    access(1, 8'h77, 0);
    check("t7_post_data", rd_data, 8'h77);
    check("t7_post_count", count, 1);

    repeat (2) @(posedge phi2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
